// File: rtl/lpc_pkg.sv
// Shared state encoding and sizing constants for the LPC frame sequencer.
package lpc_pkg;

    localparam int LPC_FRAME_LEN_DEF = 240;
    localparam int LPC_RATE_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_ENC_WAIT = 2'd2,
        ST_DEC_WAIT = 2'd3
    } lpc_state_e;

    function automatic logic is_wait_state(input lpc_state_e s);
        return (s == ST_ENC_WAIT) || (s == ST_DEC_WAIT);
    endfunction

endpackage

// File: rtl/lpc_seq_watchdog.sv
// Counts clocks spent in a wait state; the count restarts whenever a new state is entered.
module lpc_seq_watchdog
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_eff_s;

    // On the first cycle of a state the stale count is replaced by zero.
    always_comb begin
        if (start) begin
            cnt_eff_s = '0;
        end else begin
            cnt_eff_s = cnt_q;
        end
    end

    assign expired = run && (cnt_eff_s == CNT_W'(TIMEOUT_CYC - 1));

    // Wait-cycle counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_eff_s + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/lpc_frame_sequencer.sv
// Sequences sample collection, encoder and decoder hand-offs for one LPC frame at a time.
// Optional wait-state watchdog enabled by defining LPC_SEQ_TIMEOUT_EN.
module lpc_frame_sequencer
    import lpc_pkg::*;
#(
    parameter int FRAME_LEN   = LPC_FRAME_LEN_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  smp_v,
    input  logic                  enc_vout,
    input  logic                  dec_vout,
    output logic                  enc_v,
    output logic                  dec_v,
    output logic [LPC_RATE_W-1:0] lpcrate,
    output logic [LPC_RATE_W-1:0] frame_cnt,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout
);

    localparam logic [LPC_RATE_W-1:0] LAST_SMP = LPC_RATE_W'(FRAME_LEN - 1);

    lpc_state_e            state_q;
    logic [LPC_RATE_W-1:0] smp_cnt_q;
    logic [LPC_RATE_W-1:0] frame_cnt_q;
    logic                  enc_v_q;
    logic                  dec_v_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  wd_expired_s;

    // Frame FSM with sample counter, hand-off pulses and sticky overrun.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            smp_cnt_q   <= '0;
            frame_cnt_q <= '0;
            enc_v_q     <= 1'b0;
            dec_v_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            enc_v_q   <= 1'b0;
            dec_v_q   <= 1'b0;
            busy_q    <= (state_q != ST_IDLE);
            // A stray sample in the same cycle as clr keeps the flag set.
            overrun_q <= (smp_v && (state_q != ST_FILL)) || (overrun_q && !clr);
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (smp_v) begin
                        enc_v_q <= 1'b1;
                        if (smp_cnt_q == LAST_SMP) begin
                            smp_cnt_q <= '0;
                            state_q   <= ST_ENC_WAIT;
                        end else begin
                            smp_cnt_q <= smp_cnt_q + 16'd1;
                        end
                    end
                end
                ST_ENC_WAIT: begin
                    if (wd_expired_s) begin
                        smp_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (enc_vout) begin
                        dec_v_q <= 1'b1;
                        state_q <= ST_DEC_WAIT;
                    end
                end
                ST_DEC_WAIT: begin
                    if (wd_expired_s) begin
                        smp_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (dec_vout) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= en ? ST_FILL : ST_IDLE;
                    end
                end
                default: begin
                    smp_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LPC_SEQ_TIMEOUT_EN
    lpc_state_e prev_state_q;
    logic       timeout_q;
    logic       wd_start_s;
    logic       wd_run_s;

    assign wd_start_s = (state_q != prev_state_q);
    assign wd_run_s   = is_wait_state(state_q);

    // State-entry tracking and sticky timeout flag.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_state_q <= ST_IDLE;
            timeout_q    <= 1'b0;
        end else begin
            prev_state_q <= state_q;
            timeout_q    <= wd_expired_s || (timeout_q && !clr);
        end
    end

    lpc_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .start         (wd_start_s),
        .run           (wd_run_s),
        .expired       (wd_expired_s)
    );

    assign timeout = timeout_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign wd_expired_s = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign lpcrate   = LPC_RATE_W'(FRAME_LEN);
    assign frame_cnt = frame_cnt_q;
    assign enc_v     = enc_v_q;
    assign dec_v     = dec_v_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
